// File: rtl/fft_pkg.sv
// Shared types and default widths for the FFT histogram reader blocks.
package fft_pkg;

  localparam int FFT_ADDR_W = 11;
  localparam int FFT_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [FFT_ADDR_W-1:0] bin;
    logic [FFT_DATA_W-1:0] mag;
  } peak_t;

endpackage

// File: rtl/fft_peak_finder_track.sv
// Registered running-maximum tracker fed by the aligned bin/magnitude stream.
// Optional FFT_PEAK_SECOND_EN adds a runner-up kept outside +/-2 bins of the maximum.
module peak_track
  import fft_pkg::*;
#(
  parameter int ADDR_W = FFT_ADDR_W,
  parameter int DATA_W = FFT_DATA_W,
  parameter int LO_BIN = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              enable,
  input  logic [ADDR_W-1:0] in_bin,
  input  logic [DATA_W-1:0] in_mag,
  output logic [ADDR_W-1:0] top_bin_nxt,
  output logic [DATA_W-1:0] top_mag_nxt
`ifdef FFT_PEAK_SECOND_EN
  ,
  output logic [ADDR_W-1:0] sec_bin_nxt,
  output logic [DATA_W-1:0] sec_mag_nxt
`endif
);

  localparam logic [ADDR_W-1:0] LO    = ADDR_W'(LO_BIN);
  localparam logic [ADDR_W-1:0] GUARD = ADDR_W'(2);

  logic [ADDR_W-1:0] top_bin_p1;
  logic [DATA_W-1:0] top_mag_p1;
`ifdef FFT_PEAK_SECOND_EN
  logic [ADDR_W-1:0] sec_bin_p1;
  logic [DATA_W-1:0] sec_mag_p1;
`endif

  // Bins arrive in ascending order, so in_bin - top_bin is never negative.
  always_comb begin
    top_bin_nxt = top_bin_p1;
    top_mag_nxt = top_mag_p1;
`ifdef FFT_PEAK_SECOND_EN
    sec_bin_nxt = sec_bin_p1;
    sec_mag_nxt = sec_mag_p1;
`endif
    if (enable) begin
      if (in_mag > top_mag_p1) begin
        top_bin_nxt = in_bin;
        top_mag_nxt = in_mag;
`ifdef FFT_PEAK_SECOND_EN
        if ((in_bin - top_bin_p1) > GUARD) begin
          sec_bin_nxt = top_bin_p1;
          sec_mag_nxt = top_mag_p1;
        end else if ((in_bin - sec_bin_p1) <= GUARD) begin
          sec_bin_nxt = LO;
          sec_mag_nxt = '0;
        end
`endif
      end
`ifdef FFT_PEAK_SECOND_EN
      else if (((in_bin - top_bin_p1) > GUARD) && (in_mag > sec_mag_p1)) begin
        sec_bin_nxt = in_bin;
        sec_mag_nxt = in_mag;
      end
`endif
    end
  end

  // Compare stage register
  always_ff @(posedge clk) begin
    if (clear) begin
      top_bin_p1 <= LO;
      top_mag_p1 <= '0;
`ifdef FFT_PEAK_SECOND_EN
      sec_bin_p1 <= LO;
      sec_mag_p1 <= '0;
`endif
    end else begin
      top_bin_p1 <= top_bin_nxt;
      top_mag_p1 <= top_mag_nxt;
`ifdef FFT_PEAK_SECOND_EN
      sec_bin_p1 <= sec_bin_nxt;
      sec_mag_p1 <= sec_mag_nxt;
`endif
    end
  end

endmodule

// File: rtl/fft_peak_finder.sv
// Scans a bin window of the FFT histogram BRAM after each frame and publishes the peak bin.
// FFT_PEAK_SECOND_EN adds second_bin/second_mag (runner-up outside +/-2 bins of the peak).
module fft_peak_finder
  import fft_pkg::*;
#(
  parameter int ADDR_W = FFT_ADDR_W,
  parameter int DATA_W = FFT_DATA_W,
  parameter int LO_BIN = 1,
  parameter int HI_BIN = 1023,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_done,
  input  logic [DATA_W-1:0] threshold,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              peak_valid,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [DATA_W-1:0] peak_mag,
  output logic              note_present,
  output logic              overrun
`ifdef FFT_PEAK_SECOND_EN
  ,
  output logic [ADDR_W-1:0] second_bin,
  output logic [DATA_W-1:0] second_mag
`endif
);

  localparam logic [ADDR_W-1:0] LO = ADDR_W'(LO_BIN);
  localparam logic [ADDR_W-1:0] HI = ADDR_W'(HI_BIN);

  state_t            state, state_nxt;
  logic              pending;
  logic              start;
  logic              publish;
  logic [1:0]        drain_cnt;
  logic [DATA_W-1:0] thr_lat;
  logic [RD_LAT-1:0] vld_p;
  logic [ADDR_W-1:0] bin_p [RD_LAT];
  logic [ADDR_W-1:0] top_bin_nxt;
  logic [DATA_W-1:0] top_mag_nxt;
`ifdef FFT_PEAK_SECOND_EN
  logic [ADDR_W-1:0] sec_bin_nxt;
  logic [DATA_W-1:0] sec_mag_nxt;
`endif

  assign start      = (state == IDLE) && (frame_done || pending);
  assign publish    = (state == DRAIN) && (drain_cnt == 2'(RD_LAT - 1));
  assign busy       = (state != IDLE);
  assign peak_valid = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_done || pending) state_nxt = READ;
      READ:    if (raddr == HI) state_nxt = DRAIN;
      DRAIN:   if (publish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address counter, request queue and read-tag valid pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raddr     <= LO;
      pending   <= 1'b0;
      overrun   <= 1'b0;
      drain_cnt <= '0;
      vld_p     <= '0;
    end else begin
      if (state == READ) begin
        if (raddr != HI) raddr <= raddr + ADDR_W'(1);
      end else begin
        raddr <= LO;
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      // A pulse coinciding with the start of a queued scan becomes the next request.
      if (state == IDLE) begin
        pending <= pending & frame_done;
      end else if (frame_done) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
      vld_p[0] <= (state == READ);
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Address tag travels alongside the BRAM read latency
  always_ff @(posedge clk) begin
    bin_p[0] <= raddr;
    for (int i = 1; i < RD_LAT; i++) bin_p[i] <= bin_p[i-1];
    if (start) thr_lat <= threshold;
  end

  peak_track #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LO_BIN (LO_BIN)
  ) u_track (
    .clk         (clk),
    .clear       (start),
    .enable      (vld_p[RD_LAT-1]),
    .in_bin      (bin_p[RD_LAT-1]),
    .in_mag      (rdata),
    .top_bin_nxt (top_bin_nxt),
    .top_mag_nxt (top_mag_nxt)
`ifdef FFT_PEAK_SECOND_EN
    ,
    .sec_bin_nxt (sec_bin_nxt),
    .sec_mag_nxt (sec_mag_nxt)
`endif
  );

  // Result stage: loaded from the final compare so it is current during DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_bin     <= '0;
      peak_mag     <= '0;
      note_present <= 1'b0;
`ifdef FFT_PEAK_SECOND_EN
      second_bin   <= '0;
      second_mag   <= '0;
`endif
    end else if (publish) begin
      peak_bin     <= top_bin_nxt;
      peak_mag     <= top_mag_nxt;
      note_present <= (top_mag_nxt >= thr_lat);
`ifdef FFT_PEAK_SECOND_EN
      second_bin   <= sec_bin_nxt;
      second_mag   <= sec_mag_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed bench for fft_peak_finder with a 1-cycle-latency BRAM model.
module tb_fft_peak_finder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_done = 1'b0;
  logic [15:0] threshold = 16'h0000;
  logic [10:0] raddr;
  logic [15:0] rdata = 16'h0000;
  logic        busy, peak_valid, note_present, overrun;
  logic [10:0] peak_bin;
  logic [15:0] peak_mag;
`ifdef FFT_PEAK_SECOND_EN
  logic [10:0] second_bin;
  logic [15:0] second_mag;
`endif

  logic [15:0] mem [2048];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  fft_peak_finder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_done   (frame_done),
    .threshold    (threshold),
    .raddr        (raddr),
    .rdata        (rdata),
    .busy         (busy),
    .peak_valid   (peak_valid),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .note_present (note_present),
    .overrun      (overrun)
`ifdef FFT_PEAK_SECOND_EN
    ,
    .second_bin   (second_bin),
    .second_mag   (second_mag)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rdata <= mem[raddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 2048; i++) mem[i] = v;
  endtask

  // Pulses frame_done for one cycle (cycle T) and returns the cycle offset of peak_valid.
  task automatic run_scan(input logic [15:0] thr_start, input logic [15:0] thr_mid,
                          output int lat, output int ra1, output int ra2);
    int t0;
    @(negedge clk);
    threshold = thr_start;
    frame_done = 1'b1;
    t0 = cyc;
    @(negedge clk);
    frame_done = 1'b0;
    lat = -1;
    ra1 = -1;
    ra2 = -1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 0) ra1 = int'(raddr);
      if (i == 1) ra2 = int'(raddr);
      if (i == 100) threshold = thr_mid;
      if (peak_valid) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  int lat, ra1, ra2, npv, nbusy, t0, t1, t2;

  initial begin
    fill(16'h0000);
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_valid", 32'(peak_valid), 32'd0);
    check("rst_bin",   32'(peak_bin), 32'd0);
    check("rst_mag",   32'(peak_mag), 32'd0);
    check("rst_note",  32'(note_present), 32'd0);
    check("rst_ovr",   32'(overrun), 32'd0);
    check("rst_raddr", 32'(raddr), 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single strong bin over a flat floor
    fill(16'h0010);
    mem[200] = 16'h4000;
    run_scan(16'h1000, 16'h1000, lat, ra1, ra2);
    check("t1_raddr_first", 32'(ra1), 32'd1);
    check("t1_raddr_second", 32'(ra2), 32'd2);
    check("t1_latency", 32'(lat), 32'd1025);
    check("t1_bin", 32'(peak_bin), 32'd200);
    check("t1_mag", 32'(peak_mag), 32'h4000);
    check("t1_note", 32'(note_present), 32'd1);
    @(negedge clk);
    check("t1_pulse_width", 32'(peak_valid), 32'd0);
    check("t1_hold_bin", 32'(peak_bin), 32'd200);
    check("t1_idle", 32'(busy), 32'd0);

    // Tie keeps the lower bin; a mid-scan threshold change must not matter
    fill(16'h0000);
    mem[50]  = 16'h2000;
    mem[300] = 16'h2000;
    run_scan(16'h1000, 16'h3000, lat, ra1, ra2);
    check("t2_latency", 32'(lat), 32'd1025);
    check("t2_bin", 32'(peak_bin), 32'd50);
    check("t2_mag", 32'(peak_mag), 32'h2000);
    check("t2_note_latched", 32'(note_present), 32'd1);

    // Flat frame below threshold
    fill(16'h0800);
    run_scan(16'h1000, 16'h1000, lat, ra1, ra2);
    check("t3_bin", 32'(peak_bin), 32'd1);
    check("t3_mag", 32'(peak_mag), 32'h0800);
    check("t3_note", 32'(note_present), 32'd0);

    // Window edges: DC and bin 1024 excluded, HI_BIN included, full-width compare
    fill(16'h0001);
    mem[0]    = 16'hFFFF;
    mem[1024] = 16'hFFFF;
    mem[5]    = 16'h7FFF;
    mem[1023] = 16'h8000;
    run_scan(16'h8000, 16'h8000, lat, ra1, ra2);
    check("win_bin", 32'(peak_bin), 32'd1023);
    check("win_mag", 32'(peak_mag), 32'h8000);
    check("win_note_equal", 32'(note_present), 32'd1);

    // All-zero frame
    fill(16'h0000);
    run_scan(16'h0001, 16'h0001, lat, ra1, ra2);
    check("zero_bin", 32'(peak_bin), 32'd1);
    check("zero_mag", 32'(peak_mag), 32'd0);

    // Three requests: one queued, one dropped with overrun
    fill(16'h0010);
    mem[700] = 16'h0500;
    check("t4_ovr_before", 32'(overrun), 32'd0);
    @(negedge clk);
    frame_done = 1'b1;
    t0 = cyc;
    npv = 0; t1 = -1; t2 = -1;
    for (int i = 1; i < 2300; i++) begin
      @(negedge clk);
      frame_done = (i == 10 || i == 20);
      if (peak_valid) begin
        if (npv == 0) t1 = cyc - t0;
        else if (npv == 1) t2 = cyc - t0;
        npv++;
      end
    end
    frame_done = 1'b0;
    check("t4_valid_count", 32'(npv), 32'd2);
    check("t4_first_at", 32'(t1), 32'd1025);
    check("t4_second_at", 32'(t2), 32'd2051);
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_bin", 32'(peak_bin), 32'd700);

    // Reset mid-scan abandons the scan and clears everything
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    repeat (499) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_bin", 32'(peak_bin), 32'd0);
    check("t5_mag", 32'(peak_mag), 32'd0);
    check("t5_ovr", 32'(overrun), 32'd0);
    check("t5_raddr", 32'(raddr), 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    npv = 0; nbusy = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (peak_valid) npv++;
      if (busy) nbusy++;
    end
    check("t5_no_valid", 32'(npv), 32'd0);
    check("t5_stays_idle", 32'(nbusy), 32'd0);

    // Request arriving during DONE is queued without overrun
    @(negedge clk);
    frame_done = 1'b1;
    t0 = cyc;
    npv = 0; t1 = -1; t2 = -1;
    for (int i = 1; i < 2300; i++) begin
      @(negedge clk);
      frame_done = (i == 1025);
      if (peak_valid) begin
        if (npv == 0) t1 = cyc - t0;
        else if (npv == 1) t2 = cyc - t0;
        npv++;
      end
    end
    frame_done = 1'b0;
    check("done_valid_count", 32'(npv), 32'd2);
    check("done_first_at", 32'(t1), 32'd1025);
    check("done_second_at", 32'(t2), 32'd2051);
    check("done_no_overrun", 32'(overrun), 32'd0);

`ifdef FFT_PEAK_SECOND_EN
    fill(16'h0000);
    mem[100] = 16'h3000;
    mem[101] = 16'h2F00;
    mem[400] = 16'h2000;
    run_scan(16'h1000, 16'h1000, lat, ra1, ra2);
    check("t6_bin", 32'(peak_bin), 32'd100);
    check("t6_second_bin", 32'(second_bin), 32'd400);
    check("t6_second_mag", 32'(second_mag), 32'h2000);
    fill(16'h0000);
    mem[600] = 16'h0100;
    run_scan(16'h1000, 16'h1000, lat, ra1, ra2);
    check("t6_single_bin", 32'(second_bin), 32'd1);
    check("t6_single_mag", 32'(second_mag), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
